// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller for NUM_DIGITS hex digits.
// Has an internal prescaler and double-buffered digit loading that only takes
// effect on a frame boundary. It also supports per-digit blanking and decimal
// points, and leaves a dead-time gap after every digit advance.
// Optional build macro: SEV_SEG_LEAD_ZERO_BLANK_EN auto-blanks leading zeros at capture.

// Per-digit hex decoder, active-high {dp,g,f,e,d,c,b,a}.
module sev_seg_dec (
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);
  logic [6:0] w_gfe;

  // Hex glyph lookup; blank forces the whole digit including dp dark.
  always_comb begin
    w_gfe = 7'h00;
    case (i_nib)
      4'h0: w_gfe = 7'h3F;
      4'h1: w_gfe = 7'h06;
      4'h2: w_gfe = 7'h5B;
      4'h3: w_gfe = 7'h4F;
      4'h4: w_gfe = 7'h66;
      4'h5: w_gfe = 7'h6D;
      4'h6: w_gfe = 7'h7D;
      4'h7: w_gfe = 7'h07;
      4'h8: w_gfe = 7'h7F;
      4'h9: w_gfe = 7'h6F;
      4'hA: w_gfe = 7'h77;
      4'hB: w_gfe = 7'h7C;
      4'hC: w_gfe = 7'h39;
      4'hD: w_gfe = 7'h5E;
      4'hE: w_gfe = 7'h79;
      4'hF: w_gfe = 7'h71;
      default: w_gfe = 7'h00;
    endcase
    o_seg = i_blank ? 8'h00 : {i_dp, w_gfe};
  end
endmodule

module sev_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_WIDTH  = 15,
  parameter int DEAD_CYC   = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk_slw,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] i_digits_in,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic [NUM_DIGITS-1:0]   i_blank_in,
  input  logic                    i_load,
  output logic                    o_load_pending,
  output logic                    o_scan_tick,
  output logic [7:0]              o_sev_seg_leds,
  output logic [NUM_DIGITS-1:0]   o_led_enable
);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int DEAD_W = $clog2(DEAD_CYC + 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DEAD_W-1:0]     DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
  localparam logic [7:0]            SEG_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] EN_OFF    = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  logic [DIV_WIDTH-1:0]             r_presc;
  logic [IDX_W-1:0]                 r_idx;
  logic [NUM_DIGITS-1:0][3:0]       r_dig;
  logic [NUM_DIGITS-1:0]            r_dp;
  logic [NUM_DIGITS-1:0]            r_blank;
  logic                             r_pend;
  state_t                           r_state;
  logic [DEAD_W-1:0]                r_dead;
  logic [7:0]                       r_leds;
  logic [NUM_DIGITS-1:0]            r_en;

  logic                             w_tick;
  logic                             w_bound;
  logic                             w_capture;
  logic [NUM_DIGITS-1:0]            w_lz;
  logic [NUM_DIGITS-1:0][7:0]       w_seg;
  logic [7:0]                       w_seg_sel;
  logic [NUM_DIGITS-1:0]            w_onehot;
  state_t                           w_nxt_state;
  logic [DEAD_W-1:0]                w_nxt_dead;
  logic [7:0]                       w_nxt_leds;
  logic [NUM_DIGITS-1:0]            w_nxt_en;

  assign w_tick    = &r_presc;
  assign w_bound   = w_tick && (r_idx == IDX_LAST);
  assign w_capture = w_bound && (r_pend || i_load);

`ifdef SEV_SEG_LEAD_ZERO_BLANK_EN
  // Mark zero nibbles from the top down until the first nonzero; digit 0 always shows.
  always_comb begin
    logic run;
    w_lz = '0;
    run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run     = run & (i_digits_in[4*k +: 4] == 4'h0);
      w_lz[k] = run;
    end
  end
`else
  assign w_lz = '0;
`endif

  // One decoder per digit; the scan index picks which one reaches the pins.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    sev_seg_dec u_dec (
      .i_nib   (r_dig[g]),
      .i_dp    (r_dp[g]),
      .i_blank (r_blank[g]),
      .o_seg   (w_seg[g])
    );
  end

  assign w_seg_sel = w_seg[r_idx];
  assign w_onehot  = NUM_DIGITS'(1) << r_idx;

  // Free-running prescaler and digit index; index wrap to 0 is the frame boundary.
  always_ff @(posedge clk_slw) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= IDX_LAST;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_tick) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Shadow registers load only at the frame boundary, so a frame never tears.
  always_ff @(posedge clk_slw) begin
    if (reset) begin
      r_dig   <= '0;
      r_dp    <= '0;
      r_blank <= '0;
      r_pend  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_dig   <= i_digits_in;
        r_dp    <= i_dp_in;
        r_blank <= i_blank_in | w_lz;
      end
      if (w_bound)     r_pend <= 1'b0;
      else if (i_load) r_pend <= 1'b1;
    end
  end

  // Next state: dead-time count in BLANK, leave DRIVE on every tick.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_dead  = r_dead;
    w_nxt_leds  = SEG_OFF;
    w_nxt_en    = EN_OFF;
    case (r_state)
      ST_BLANK: begin
        if (w_tick) begin
          w_nxt_dead = '0;
        end else if (r_dead == DEAD_LAST) begin
          w_nxt_state = ST_DRIVE;
          w_nxt_dead  = '0;
        end else begin
          w_nxt_dead = r_dead + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (w_tick) begin
          w_nxt_state = ST_BLANK;
          w_nxt_dead  = '0;
        end
      end
      default: begin
        w_nxt_state = ST_BLANK;
        w_nxt_dead  = '0;
      end
    endcase
    // Index and shadow never change on a cycle that enters or stays in DRIVE.
    if (w_nxt_state == ST_DRIVE) begin
      w_nxt_leds = w_seg_sel ^ SEG_OFF;
      w_nxt_en   = w_onehot ^ EN_OFF;
    end
  end

  // FSM state and registered pin outputs.
  always_ff @(posedge clk_slw) begin
    if (reset) begin
      r_state <= ST_BLANK;
      r_dead  <= '0;
      r_leds  <= SEG_OFF;
      r_en    <= EN_OFF;
    end else begin
      r_state <= w_nxt_state;
      r_dead  <= w_nxt_dead;
      r_leds  <= w_nxt_leds;
      r_en    <= w_nxt_en;
    end
  end

  assign o_load_pending = r_pend;
  assign o_scan_tick    = w_tick;
  assign o_sev_seg_leds = r_leds;
  assign o_led_enable   = r_en;
endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Bench for sev_seg_scan_ctrl (4 digits, 8-cycle tick period, 2 dead cycles, active-low).
// A cycle-indexed model predicts every output from the cycle count since reset;
// literal checks pin known display values.
module tb_sev_seg_scan_ctrl;
  logic        clk_slw = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp, blank;
  logic        load;
  logic        pend, tick;
  logic [7:0]  leds;
  logic [3:0]  en;

  int n_tests = 0;
  int n_fail  = 0;
  int sc      = 0;

  sev_seg_scan_ctrl #(.NUM_DIGITS(4), .DIV_WIDTH(3), .DEAD_CYC(2), .ACTIVE_LOW(1)) dut (
    .clk_slw        (clk_slw),
    .reset          (reset),
    .i_digits_in    (digits),
    .i_dp_in        (dp),
    .i_blank_in     (blank),
    .i_load         (load),
    .o_load_pending (pend),
    .o_scan_tick    (tick),
    .o_sev_seg_leds (leds),
    .o_led_enable   (en)
  );

  always #5 clk_slw = ~clk_slw;

  // Hex glyphs, active-high gfedcba.
  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Model: cycle c since reset; tick every c%8==7, dark for c%8<2, frame boundary at c%32==7.
  bit         mvalid = 0;
  int         mc     = 0;
  bit         mpend  = 0;
  logic [3:0] mdig [4];
  logic [3:0] mdp    = '0;
  logic [3:0] mblank = '0;

  function automatic logic [3:0] lz_mask(input logic [15:0] d);
    logic [3:0] m;
    bit         zero_run;
    m = '0;
`ifdef SEV_SEG_LEAD_ZERO_BLANK_EN
    zero_run = 1;
    for (int k = 3; k >= 1; k--) begin
      if (d[4*k +: 4] != 4'h0) zero_run = 0;
      if (zero_run) m[k] = 1'b1;
    end
`else
    zero_run = 0;
`endif
    return m;
  endfunction

  // Per-cycle compare against the model, then advance it with this cycle's inputs.
  always @(negedge clk_slw) begin
    int         idx;
    logic [7:0] e_leds;
    logic [3:0] e_en;
    if (mvalid) begin
      idx = (3 + mc / 8) % 4;
      if (mc % 8 < 2) begin
        e_leds = 8'hFF;
        e_en   = 4'hF;
      end else begin
        e_leds = mblank[idx] ? 8'hFF : ~(glyph[mdig[idx]] | {mdp[idx], 7'h00});
        e_en   = ~(4'b0001 << idx);
      end
      n_tests++;
      if (leds !== e_leds || en !== e_en || tick !== (mc % 8 == 7) || pend !== mpend) begin
        n_fail++;
        $display("FAIL model c=%0d: leds=%h en=%h tick=%b pend=%b, want leds=%h en=%h tick=%b pend=%b",
                 mc, leds, en, tick, pend, e_leds, e_en, (mc % 8 == 7), mpend);
      end
    end
    if (reset) begin
      mvalid = 1;
      mc     = 0;
      mpend  = 0;
      for (int k = 0; k < 4; k++) mdig[k] = 4'h0;
      mdp    = '0;
      mblank = '0;
    end else if (mvalid) begin
      if (mc % 32 == 7) begin
        if (load || mpend) begin
          for (int k = 0; k < 4; k++) mdig[k] = digits[4*k +: 4];
          mdp    = dp;
          mblank = blank | lz_mask(digits);
        end
        mpend = 0;
      end else if (load) begin
        mpend = 1;
      end
      mc++;
    end
  end

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic adv1();
    @(posedge clk_slw);
    sc++;
    #1;
  endtask

  task automatic at_cyc(input int t);
    while (sc < t) adv1();
  endtask

  task automatic sample();
    @(negedge clk_slw);
    #1;
  endtask

  initial begin
    bit found;
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    reset = 1; load = 0; digits = '0; dp = '0; blank = '0;
    adv1(); adv1();
    sample();
    lit("rst_leds", 16'(leds), 16'h00FF);
    lit("rst_en",   16'(en),   16'h000F);
    lit("rst_pend", 16'(pend), 16'h0000);
    lit("rst_tick", 16'(tick), 16'h0000);
    adv1();
    reset = 0; digits = 16'h1234; load = 1; sc = 0;
    at_cyc(1); load = 0;
    sample(); lit("pend_after_load", 16'(pend), 16'h0001);
    found = 0;
    while (!found && sc < 20) begin
      adv1(); sample();
      if (tick) found = 1;
    end
    lit("first_tick_cyc", 16'(sc), 16'd7);
    lit("pend_at_tick", 16'(pend), 16'h0001);
    at_cyc(8);  sample(); lit("pend_cleared", 16'(pend), 16'h0000); lit("dead_en", 16'(en), 16'h000F);
    at_cyc(10); sample(); lit("d0_en", 16'(en), 16'h000E); lit("d0_4", 16'(leds), 16'h0099);
    at_cyc(18); sample(); lit("d1_en", 16'(en), 16'h000D); lit("d1_3", 16'(leds), 16'h00B0);
    at_cyc(26); sample(); lit("d2_en", 16'(en), 16'h000B); lit("d2_2", 16'(leds), 16'h00A4);
    at_cyc(34); sample(); lit("d3_en", 16'(en), 16'h0007); lit("d3_1", 16'(leds), 16'h00F9);
    // mid-frame load must wait for the next wrap
    at_cyc(35); digits = 16'hABCD; load = 1;
    at_cyc(36); load = 0; sample(); lit("mid_pend", 16'(pend), 16'h0001);
    at_cyc(38); sample(); lit("no_tear", 16'(leds), 16'h00F9);
    at_cyc(42); sample(); lit("abcd_d0", 16'(leds), 16'h00A1); lit("abcd_pend", 16'(pend), 16'h0000);
    at_cyc(50); sample(); lit("abcd_d1", 16'(leds), 16'h00C6);
    at_cyc(58); sample(); lit("abcd_d2", 16'(leds), 16'h0083);
    at_cyc(66); sample(); lit("abcd_d3", 16'(leds), 16'h0088);
    // load on the boundary tick itself
    at_cyc(71); digits = 16'h1234; dp = 4'b0010; blank = 4'b1000; load = 1;
    sample(); lit("bound_tick", 16'(tick), 16'h0001);
    at_cyc(72); load = 0; sample(); lit("coinc_pend", 16'(pend), 16'h0000);
    at_cyc(82); sample(); lit("dp_d1", 16'(leds), 16'h0030); lit("dp_en", 16'(en), 16'h000D);
    at_cyc(98); sample(); lit("blank_d3", 16'(leds), 16'h00FF); lit("blank_en", 16'(en), 16'h0007);
    // leading zeros
    at_cyc(100); digits = 16'h0050; dp = '0; blank = '0; load = 1;
    at_cyc(101); load = 0;
    at_cyc(106); sample(); lit("lz_d0", 16'(leds), 16'h00C0);
    at_cyc(114); sample(); lit("lz_d1", 16'(leds), 16'h0092);
`ifdef SEV_SEG_LEAD_ZERO_BLANK_EN
    at_cyc(122); sample(); lit("lz_d2", 16'(leds), 16'h00FF);
    at_cyc(130); sample(); lit("lz_d3", 16'(leds), 16'h00FF);
`else
    at_cyc(122); sample(); lit("lz_d2", 16'(leds), 16'h00C0);
    at_cyc(130); sample(); lit("lz_d3", 16'(leds), 16'h00C0);
`endif
    // reset mid-DRIVE with a load pending
    at_cyc(132); load = 1;
    at_cyc(133); load = 0; reset = 1;
    at_cyc(134); reset = 0; sc = 0;
    sample();
    lit("mrst_leds", 16'(leds), 16'h00FF);
    lit("mrst_en",   16'(en),   16'h000F);
    lit("mrst_pend", 16'(pend), 16'h0000);
    at_cyc(2);  sample(); lit("mrst_d3", 16'(leds), 16'h00C0); lit("mrst_d3_en", 16'(en), 16'h0007);
    at_cyc(10); sample(); lit("mrst_d0_nocap", 16'(leds), 16'h00C0);
    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      adv1();
      reset  = ($urandom_range(0, 299) == 0);
      load   = ($urandom_range(0, 9) == 0);
      digits = 16'($urandom) & masks[$urandom_range(0, 4)];
      dp     = 4'($urandom);
      blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    end
    adv1();
    reset = 0; load = 0;
    repeat (40) adv1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
